// File: rtl/cordic_input_sequencer_pkg.sv
// rtl/cordic_input_sequencer_pkg.sv - shared state encodings, widths and function-code helpers
package cordic_input_sequencer_pkg;

  localparam int OPW              = 16;
  localparam int RESW             = 32;
  localparam int MAX_FUNC_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FUNC   = 3'd1,
    ST_OP1    = 3'd2,
    ST_OP2    = 3'd3,
    ST_START  = 3'd4,
    ST_WAIT   = 3'd5,
    ST_RESULT = 3'd6
  } seq_state_e;

  // Codes 0, 1 and 7 take two operands; every other legal code takes one.
  function automatic logic is_two_operand(input logic [3:0] code);
    return (code == 4'd0) || (code == 4'd1) || (code == 4'd7);
  endfunction

endpackage

// File: rtl/st_conditioner.sv
// rtl/st_conditioner.sv - step button synchroniser, debounce and single-pulse press detector
module st_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic st_i,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DEBOUNCE_CYCLES);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Counter saturates while held so a long press yields a single pulse.
  always_comb begin
    cnt_d   = cnt_q;
    press_d = sync_q[1] && (cnt_q == CNT_LAST);
    if (!sync_q[1]) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], st_i};
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/cordic_input_sequencer.sv
// rtl/cordic_input_sequencer.sv - button-stepped entry of function code and operands for a CORDIC core
module cordic_input_sequencer
  import cordic_input_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1,
  parameter int MAX_FUNC        = MAX_FUNC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            st,
  input  logic [OPW-1:0]  sw_in,
  input  logic            core_done,
  input  logic [RESW-1:0] core_result,
  output logic [3:0]      func,
  output logic [OPW-1:0]  op1,
  output logic [OPW-1:0]  op2,
  output logic            go,
  output logic [RESW-1:0] result,
  output logic            result_valid,
  output logic [2:0]      phase,
  output logic            err
);

  localparam logic [3:0] MAX_CODE = 4'(MAX_FUNC);

  seq_state_e      state_q;
  logic [3:0]      func_q;
  logic [OPW-1:0]  op1_q, op2_q;
  logic [RESW-1:0] result_q;
  logic            go_q, result_valid_q, err_q;
  logic            press;

  st_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_st_conditioner (
    .clk    (clk),
    .rst_n  (rst_n),
    .st_i   (st),
    .press_o(press)
  );

  // Presses are only consulted in entry states, so START/WAIT presses drop on the floor.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      func_q         <= '0;
      op1_q          <= '0;
      op2_q          <= '0;
      result_q       <= '0;
      go_q           <= 1'b0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      go_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (press) state_q <= ST_FUNC;
        ST_FUNC: begin
          if (press) begin
            if (sw_in[3:0] <= MAX_CODE) begin
              func_q <= sw_in[3:0];
              err_q  <= 1'b0;
              if (is_two_operand(sw_in[3:0])) begin
                state_q <= ST_OP1;
              end else begin
                op1_q   <= '0;
                state_q <= ST_OP2;
              end
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_OP1: begin
          if (press) begin
            op1_q   <= sw_in;
            state_q <= ST_OP2;
          end
        end
        ST_OP2: begin
          if (press) begin
            op2_q   <= sw_in;
            go_q    <= 1'b1;
            state_q <= ST_START;
          end
        end
        ST_START: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (core_done) begin
            result_q       <= core_result;
            result_valid_q <= 1'b1;
            state_q        <= ST_RESULT;
          end
        end
        ST_RESULT: begin
          if (press) begin
            result_valid_q <= 1'b0;
            state_q        <= ST_FUNC;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign func         = func_q;
  assign op1          = op1_q;
  assign op2          = op2_q;
  assign go           = go_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign phase        = state_q;
  assign err          = err_q;

endmodule

// File: doc/cordic_input_sequencer.md
CORDIC_INPUT_SEQUENCER -- requirements
Module: cordic_input_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1: consecutive high samples of synchronised st that count as a press.
REQ-002 Parameter MAX_FUNC, default 8: highest legal function code.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 st  in  1  raw step/enter button, asynchronous to clk.
REQ-006 sw_in  in  16  switch bank: function code in [3:0], or Q2.14 operand (0x4000 = 1.0).
REQ-007 core_done  in  1  one-cycle pulse from CORDIC core; result valid.
REQ-008 core_result  in  32  CORDIC result, valid with core_done.
REQ-009 func  out  4  latched function code.
REQ-010 op1  out  16  latched first operand.
REQ-011 op2  out  16  latched second operand.
REQ-012 go  out  1  one-cycle start pulse to core.
REQ-013 result  out  32  latched result for display stage.
REQ-014 result_valid  out  1  high while result is displayable.
REQ-015 phase  out  3  current state encoding, drives display prompt.
REQ-016 err  out  1  sticky illegal-function flag.

Function
REQ-017 st SHALL pass a 2-flop synchroniser, then debounce; one press SHALL yield exactly one one-cycle internal press pulse on the qualifying rising edge.
REQ-018 States SHALL be IDLE, FUNC, OP1, OP2, START, WAIT, RESULT.
REQ-019 IDLE: press -> FUNC; nothing latched.
REQ-020 FUNC: on press, if sw_in[3:0] <= MAX_FUNC, latch func, clear err, go to OP1 for two-operand codes (0, 1, 7), else to OP2.
REQ-021 FUNC: on press with sw_in[3:0] > MAX_FUNC, set err, stay in FUNC, keep func unchanged.
REQ-022 FUNC -> OP2 (one-operand path) SHALL clear op1 to 0x0000 in the same cycle.
REQ-023 OP1: press latches op1 = sw_in -> OP2.
REQ-024 OP2: press latches op2 = sw_in -> START.
REQ-025 START: go SHALL be high for exactly this one cycle, then WAIT; func/op1/op2 SHALL be stable from START until core_done.
REQ-026 WAIT: on core_done, latch result = core_result, set result_valid -> RESULT; presses in START/WAIT SHALL be ignored, not queued.
REQ-027 RESULT: press clears result_valid -> FUNC; result holds its value until the next core_done.
REQ-028 A press and core_done in the same WAIT cycle: core_done wins; the press is discarded.
REQ-029 go-to-state latency: START is entered the cycle after the OP2 press pulse; go is asserted one cycle after that pulse.
REQ-030 phase encoding: IDLE=0, FUNC=1, OP1=2, OP2=3, START=4, WAIT=5, RESULT=6.

Reset
REQ-031 With rst_n low at a clock edge, state SHALL become IDLE; func, op1, op2 = 0, result = 0, result_valid, go, and err = 0; synchroniser and debounce counter cleared.
REQ-032 Reset mid-WAIT SHALL abandon the operation; a later stray core_done in IDLE SHALL be ignored.

Structure
REQ-033 A shared package SHALL hold the state encodings, MAX_FUNC, the two-operand code set, and the operand width (16).
REQ-034 Button synchronise, debounce, and edge detection SHALL be one sub-module, st_conditioner.

Verification
REQ-035 Func 0: enter 0x0000, then 0x4000, then 0x0000 -> one go pulse with func=0, op1=0x4000, op2=0x0000; core_done with core_result=0x12345678 -> result=0x12345678, result_valid=1, phase=6.
REQ-036 Func 3: enter 0x0003, then 0x6488 -> OP1 skipped, go with op1=0x0000, op2=0x6488.
REQ-037 Enter 0x0009 in FUNC -> err=1, phase stays 1; then enter 0x0007 -> err=0, phase=2.
REQ-038 Presses during WAIT, plus a press coincident with core_done -> no second go, and the transition to RESULT is taken.
REQ-039 DEBOUNCE_CYCLES=4: 3-cycle st glitch -> no press; 6-cycle high -> exactly one press.
REQ-040 rst_n low during WAIT, then core_done pulse -> phase=0, result_valid=0, result=0.
